// File: rtl/sqrt_square_recon_if.sv
// Handshake/operand bundle for sqrt_square_recon.
// The exp_rad/match pair exists only when SQRT_RECON_CHECK_EN is defined.
interface sqrt_square_recon_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] root;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] rad;
  logic             ovf;
  logic             frac_err;
`ifdef SQRT_RECON_CHECK_EN
  logic [WIDTH-1:0] exp_rad;
  logic             match;

  modport master (output start, root, rem, exp_rad,
                  input  busy, valid, rad, ovf, frac_err, match);
  modport slave  (input  start, root, rem, exp_rad,
                  output busy, valid, rad, ovf, frac_err, match);
`else
  modport master (output start, root, rem,
                  input  busy, valid, rad, ovf, frac_err);
  modport slave  (input  start, root, rem,
                  output busy, valid, rad, ovf, frac_err);
`endif
endinterface

// File: rtl/sqrt_square_recon.sv
// Rebuilds a radicand from (root, rem): rad = (root*root + rem) >> FBITS, one root bit per clock.
// Optional expected-value compare enabled by defining SQRT_RECON_CHECK_EN.
module sqrt_square_recon #(
  parameter int WIDTH = 8,
  parameter int FBITS = 0
) (
  input  logic               clk,
  input  logic               rst,
  sqrt_square_recon_if.slave bus
);
  localparam int ACC_W = 2*WIDTH + 1;
  localparam int MC_W  = 2*WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);
  // Selects sum[FBITS-1:0]; all-zero when FBITS==0 so frac_err ties low.
  localparam logic [ACC_W-1:0] FRAC_MASK = (ACC_W'(1) << FBITS) - ACC_W'(1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;

  logic [ACC_W-1:0] acc;
  logic [MC_W-1:0]  mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum;
  logic             busy;
  logic             last;

  logic [WIDTH-1:0] rad_q;
  logic             ovf_q;
  logic             frac_q;
  logic             valid_q;

  logic [WIDTH-1:0] rad_n;
  logic             ovf_n;
  logic             frac_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (bus.start)                 state_n = RUN;
    else if (state == RUN && cnt == LAST) state_n = IDLE;
  end

  always_comb begin
    busy = (state == RUN);
    last = busy && (cnt == LAST) && !bus.start;
  end

  // Partial product for this root bit; sum also serves as the final result on the last step.
  always_comb begin
    sum    = acc + (mplier[0] ? ACC_W'(mcand) : '0);
    rad_n  = sum[FBITS+WIDTH-1:FBITS];
    ovf_n  = |(sum >> (FBITS + WIDTH));
    frac_n = |(sum & FRAC_MASK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      rad_q   <= '0;
      ovf_q   <= 1'b0;
      frac_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (bus.start) begin
      acc     <= ACC_W'(bus.rem);
      mcand   <= MC_W'(bus.root);
      mplier  <= bus.root;
      cnt     <= '0;
      valid_q <= 1'b0;
    end else if (busy) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= last ? '0 : cnt + CNT_W'(1);
      if (last) begin
        rad_q   <= rad_n;
        ovf_q   <= ovf_n;
        frac_q  <= frac_n;
        valid_q <= 1'b1;
      end
    end
  end

`ifdef SQRT_RECON_CHECK_EN
  logic [WIDTH-1:0] exp_q;
  logic             match_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q   <= '0;
      match_q <= 1'b0;
    end else if (bus.start) begin
      exp_q   <= bus.exp_rad;
      match_q <= 1'b0;
    end else if (last) begin
      match_q <= (rad_n == exp_q) && !ovf_n && !frac_n;
    end
  end

  assign bus.match = match_q;
`endif

  assign bus.busy     = busy;
  assign bus.valid    = valid_q;
  assign bus.rad      = rad_q;
  assign bus.ovf      = ovf_q;
  assign bus.frac_err = frac_q;
endmodule

// File: tb/tb_sqrt_square_recon.sv
// Scoreboard bench for sqrt_square_recon: one DUT with FBITS=0, one with FBITS=4.
module tb_sqrt_square_recon;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sqrt_square_recon_if #(.WIDTH(8)) ifa();
  sqrt_square_recon_if #(.WIDTH(8)) ifb();

  sqrt_square_recon #(.WIDTH(8), .FBITS(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  sqrt_square_recon #(.WIDTH(8), .FBITS(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct {
    logic [7:0] rad;
    logic       ovf;
    logic       frac;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;
  int   rises_a = 0;

  always @(posedge ifa.valid) rises_a++;

  function automatic exp_t model(input int r, input int m, input int f);
    exp_t e;
    int   s;
    s      = r*r + m;
    e.rad  = 8'((s >> f) & 255);
    e.ovf  = ((s >> (f + 8)) != 0);
    e.frac = (f == 0) ? 1'b0 : ((s & ((1 << f) - 1)) != 0);
    return e;
  endfunction

  task automatic issue(input bit sel, input int r, input int m, input int e);
    if (!sel) begin
      ifa.start = 1'b1; ifa.root = 8'(r); ifa.rem = 8'(m);
`ifdef SQRT_RECON_CHECK_EN
      ifa.exp_rad = 8'(e);
`endif
      q_a.push_back(model(r, m, 0));
    end else begin
      ifb.start = 1'b1; ifb.root = 8'(r); ifb.rem = 8'(m);
`ifdef SQRT_RECON_CHECK_EN
      ifb.exp_rad = 8'(e);
`endif
      q_b.push_back(model(r, m, 4));
    end
    if (e < 0) $display("note: negative exp_rad %0d", e);
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, output int bcyc, output bit tmo);
    bcyc = 0;
    tmo  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (sel ? ifb.valid : ifa.valid) begin
        tmo = 1'b0;
        break;
      end
      if (sel ? ifb.busy : ifa.busy) bcyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifa.busy, ifa.valid, ifa.rad, ifa.ovf, ifa.frac_err} !== 12'h0) begin
      errors++;
      $display("FAIL reset_a: got busy=%b valid=%b rad=%h ovf=%b frac=%b, want all 0",
               ifa.busy, ifa.valid, ifa.rad, ifa.ovf, ifa.frac_err);
    end
    checks++;
    if ({ifb.busy, ifb.valid, ifb.rad, ifb.ovf, ifb.frac_err} !== 12'h0) begin
      errors++;
      $display("FAIL reset_b: got busy=%b valid=%b rad=%h, want all 0", ifb.busy, ifb.valid, ifb.rad);
    end
`ifdef SQRT_RECON_CHECK_EN
    checks++;
    if (ifa.match !== 1'b0) begin
      errors++;
      $display("FAIL reset_match: got %b want 0", ifa.match);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one op and compares latency and result with the scoreboard head.
  task automatic test_ops(input bit sel, input int r, input int m, input string nm);
    int   bc;
    bit   to;
    exp_t e;
    issue(sel, r, m, 0);
    wait_valid(sel, bc, to);
    e = sel ? q_b.pop_front() : q_a.pop_front();
    checks++;
    if (to || bc != 8) begin
      errors++;
      $display("FAIL %s_latency: got busy cycles %0d timeout %0d, want 8 timeout 0", nm, bc, to);
    end
    checks++;
    if (!sel && {ifa.rad, ifa.ovf, ifa.frac_err} !== {e.rad, e.ovf, e.frac} ||
         sel && {ifb.rad, ifb.ovf, ifb.frac_err} !== {e.rad, e.ovf, e.frac}) begin
      errors++;
      $display("FAIL %s_result: got rad=%h ovf=%b frac=%b, want rad=%h ovf=%b frac=%b", nm,
               sel ? ifb.rad : ifa.rad, sel ? ifb.ovf : ifa.ovf, sel ? ifb.frac_err : ifa.frac_err,
               e.rad, e.ovf, e.frac);
    end
  endtask

  task automatic test_restart();
    int   bc, r0;
    bit   to;
    exp_t e;
    r0 = rises_a;
    issue(0, 15, 3, 0);
    repeat (2) @(negedge clk);
    issue(0, 7, 1, 0);
    e = q_a.pop_front();                 // aborted op yields no result
    wait_valid(0, bc, to);
    e = q_a.pop_front();
    checks++;
    if (to || bc != 8 || ifa.rad !== 8'd50 || ifa.rad !== e.rad) begin
      errors++;
      $display("FAIL restart: got rad=%0d busy cycles %0d timeout %0d, want rad=50 cycles 8", ifa.rad, bc, to);
    end
    @(negedge clk);
    checks++;
    if (rises_a - r0 != 1) begin
      errors++;
      $display("FAIL restart_pulses: got %0d valid rises, want 1", rises_a - r0);
    end
  endtask

  task automatic test_back_to_back();
    int   bc, r0;
    bit   to;
    exp_t e;
    r0 = rises_a;
    issue(0, 15, 3, 0);
    repeat (7) @(negedge clk);
    issue(0, 7, 1, 0);                   // start lands on the completion edge
    e = q_a.pop_front();
    checks++;
    if (ifa.valid !== 1'b0 || ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_at_done: got valid=%b busy=%b, want valid=0 busy=1", ifa.valid, ifa.busy);
    end
    wait_valid(0, bc, to);
    e = q_a.pop_front();
    checks++;
    if (to || bc != 8 || ifa.rad !== e.rad || rises_a - r0 != 1) begin
      errors++;
      $display("FAIL back_to_back: got rad=%0d cycles %0d rises %0d, want rad=%0d cycles 8 rises 1",
               ifa.rad, bc, rises_a - r0, e.rad);
    end
  endtask

  task automatic test_reset_mid();
    int   r0;
    exp_t e;
    r0 = rises_a;
    issue(0, 15, 3, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ifa.busy !== 1'b0 || ifa.valid !== 1'b0 || ifa.rad !== 8'h0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b valid=%b rad=%h, want 0 0 00", ifa.busy, ifa.valid, ifa.rad);
    end
    e = q_a.pop_front();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (ifa.valid !== 1'b0 || rises_a != r0) begin
      errors++;
      $display("FAIL reset_mid_no_valid: got valid=%b rises %0d, want 0 0", ifa.valid, rises_a - r0);
    end
  endtask

`ifdef SQRT_RECON_CHECK_EN
  task automatic test_match();
    int   bc;
    bit   to;
    exp_t e;
    int   rr[3] = '{12, 12, 16};
    int   mm[3] = '{5, 5, 0};
    int   ee[3] = '{149, 148, 0};
    logic want[3] = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      issue(0, rr[k], mm[k], ee[k]);
      checks++;
      if (ifa.match !== 1'b0) begin
        errors++;
        $display("FAIL match_clear_%0d: got %b want 0", k, ifa.match);
      end
      wait_valid(0, bc, to);
      e = q_a.pop_front();
      checks++;
      if (to || ifa.match !== want[k]) begin
        errors++;
        $display("FAIL match_%0d: got %b timeout %0d, want %b", k, ifa.match, to, want[k]);
      end
    end
  endtask
`endif

  task automatic test_closed_loop();
    int   bc, rt, bad;
    bit   to;
    exp_t e;
    bad = 0;
    for (int r = 0; r < 256; r++) begin
      rt = 0;
      while ((rt + 1) * (rt + 1) <= r) rt++;
      issue(0, rt, r - rt*rt, 0);
      wait_valid(0, bc, to);
      e = q_a.pop_front();
      checks++;
      if (to || ifa.rad !== 8'(r) || ifa.ovf !== 1'b0 || ifa.rad !== e.rad) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL loop_%0d: got rad=%0d ovf=%b timeout %0d, want rad=%0d ovf=0", r, ifa.rad, ifa.ovf, to, r);
      end
    end
  endtask

  initial begin
    ifa.start = 1'b0; ifa.root = '0; ifa.rem = '0;
    ifb.start = 1'b0; ifb.root = '0; ifb.rem = '0;
`ifdef SQRT_RECON_CHECK_EN
    ifa.exp_rad = '0; ifb.exp_rad = '0;
`endif
    test_reset();
    test_ops(0, 15, 3, "basic");
    test_ops(0, 16, 0, "ovf16");
    test_ops(0, 255, 255, "max");
    test_ops(0, 0, 77, "root0");
    test_ops(1, 8'h18, 0, "frac_exact");
    test_ops(1, 8'h11, 0, "frac_err");
    test_ops(1, 0, 8'h2B, "frac_root0");
    test_restart();
    test_back_to_back();
    test_reset_mid();
`ifdef SQRT_RECON_CHECK_EN
    test_match();
`endif
    test_closed_loop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
